// File: rtl/wb_arbiter_m1.sv
// wb_arbiter_m1: round-robin writeback arbiter merging ALU and load results into one register-file write port
module wb_arbiter_m1_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         empty_o,
  output logic [W-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push;
  assign ready_o = en_i && cnt_q < (AW+1)'(DEPTH);
  assign push    = valid_i && ready_o;
  assign empty_o = cnt_q == '0;
  assign data_o  = mem_q[rptr_q];
  assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop_i) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= data_i;
endmodule

module wb_arbiter_m1 #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic        write_en,
  output logic [3:0]  writeback_addr,
  output logic [15:0] data_in,
  output logic        idle
);
  typedef enum logic {PRI_ALU, PRI_MEM} prio_e;
  prio_e       prio_q, prio_d;
  logic        alu_empty, mem_empty, grant_alu, grant_mem, hit;
  logic [19:0] alu_head, mem_head, sel;
  logic        write_en_q, write_en_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  wb_arbiter_m1_fifo #(.DEPTH(DEPTH), .W(20)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .en_i(clk_en), .valid_i(alu_valid), .pop_i(grant_alu),
    .data_i({alu_addr, alu_data}), .ready_o(alu_ready), .empty_o(alu_empty), .data_o(alu_head)
  );
  wb_arbiter_m1_fifo #(.DEPTH(DEPTH), .W(20)) u_mem_fifo (
    .clk(clk), .rst_n(rst_n), .en_i(clk_en), .valid_i(mem_valid), .pop_i(grant_mem),
    .data_i({mem_addr, mem_data}), .ready_o(mem_ready), .empty_o(mem_empty), .data_o(mem_head)
  );
  // addr-0 entries still win arbitration and free their slot, but never strobe the register file
  always_comb begin
    grant_alu  = clk_en && !alu_empty && (mem_empty || prio_q == PRI_ALU);
    grant_mem  = clk_en && !mem_empty && !grant_alu;
    sel        = grant_alu ? alu_head : mem_head;
    hit        = (grant_alu || grant_mem) && sel[19:16] != 4'd0;
    prio_d     = grant_alu ? PRI_MEM : grant_mem ? PRI_ALU : prio_q;
    write_en_d = clk_en ? hit : write_en_q;
    addr_d     = hit ? sel[19:16] : addr_q;
    data_d     = hit ? sel[15:0] : data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio_q     <= PRI_ALU;
      write_en_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      prio_q     <= prio_d;
      write_en_q <= write_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  assign write_en       = write_en_q;
  assign writeback_addr = addr_q;
  assign data_in        = data_q;
  assign idle           = alu_empty && mem_empty && !write_en_q;
endmodule

// File: tb/tb_wb_arbiter_m1.sv
// tb_wb_arbiter_m1: random and directed stimulus checked against a queue-based model of the arbiter
module tb_wb_arbiter_m1;
  localparam int DEPTH = 2;
  logic        clk = 1'b0, rst_n, clk_en;
  logic        alu_valid, mem_valid, alu_ready, mem_ready, write_en, idle;
  logic [3:0]  alu_addr, mem_addr, writeback_addr;
  logic [15:0] alu_data, mem_data, data_in;
  logic [19:0] aq[$], mq[$];
  bit          prio;
  logic        m_we;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  int          vectors = 0, errors = 0;
  wb_arbiter_m1 #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .write_en(write_en), .writeback_addr(writeback_addr), .data_in(data_in), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset;
    aq.delete();
    mq.delete();
    prio   = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask
  // one round-robin pop then the pushes, evaluated before the edge the DUT will see
  task automatic model_advance;
    bit ar, mr, ga, gm;
    logic [19:0] e;
    if (!rst_n || !clk_en) return;
    ar = aq.size() < DEPTH;
    mr = mq.size() < DEPTH;
    ga = aq.size() != 0 && (mq.size() == 0 || !prio);
    gm = !ga && mq.size() != 0;
    m_we = 1'b0;
    if (ga || gm) begin
      if (ga) e = aq.pop_front();
      else e = mq.pop_front();
      prio = ga;
      if (e[19:16] != 4'd0) begin
        m_we   = 1'b1;
        m_addr = e[19:16];
        m_data = e[15:0];
      end
    end
    if (alu_valid && ar) aq.push_back({alu_addr, alu_data});
    if (mem_valid && mr) mq.push_back({mem_addr, mem_data});
  endtask
  task automatic compare;
    chk("alu_ready", 16'(alu_ready), 16'(clk_en && aq.size() < DEPTH));
    chk("mem_ready", 16'(mem_ready), 16'(clk_en && mq.size() < DEPTH));
    chk("write_en", 16'(write_en), 16'(m_we));
    chk("writeback_addr", 16'(writeback_addr), 16'(m_addr));
    chk("data_in", data_in, m_data);
    chk("idle", 16'(idle), 16'(aq.size() == 0 && mq.size() == 0 && !m_we));
  endtask
  task automatic step(input bit en, input bit av, input logic [3:0] aa, input logic [15:0] ad,
                      input bit mv, input logic [3:0] ma, input logic [15:0] md);
    clk_en    = en;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
    model_advance();
    @(negedge clk);
    compare();
  endtask
  task automatic idle_step;
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
  endtask
  // reset lands between edges, so outputs must drop without waiting for a clock
  task automatic pulse_reset;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_async_we", 16'(write_en), 16'd0);
    compare();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    clk_en = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_addr = '0;
    alu_data = '0;
    mem_addr = '0;
    mem_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_write_en", 16'(write_en), 16'd0);
    chk("rst_idle", 16'(idle), 16'd1);
    chk("rst_alu_ready", 16'(alu_ready), 16'd1);
    chk("rst_addr", 16'(writeback_addr), 16'd0);
    chk("rst_data", data_in, 16'd0);
    compare();
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0);
    chk("single_c1_we", 16'(write_en), 16'd0);
    idle_step();
    chk("single_c2_we", 16'(write_en), 16'd1);
    chk("single_c2_addr", 16'(writeback_addr), 16'd3);
    chk("single_c2_data", data_in, 16'h1234);
    idle_step();
    chk("single_c3_we", 16'(write_en), 16'd0);
    chk("single_c3_idle", 16'(idle), 16'd1);
    step(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0);
    idle_step();
    chk("addr0_c2_we", 16'(write_en), 16'd0);
    chk("addr0_c2_idle", 16'(idle), 16'd1);
    chk("addr0_c2_data", data_in, 16'h1234);
    pulse_reset();
    step(1'b1, 1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'h5555);
    idle_step();
    chk("pair_c2_addr", 16'(writeback_addr), 16'd1);
    chk("pair_c2_data", data_in, 16'hAAAA);
    idle_step();
    chk("pair_c3_addr", 16'(writeback_addr), 16'd2);
    chk("pair_c3_data", data_in, 16'h5555);
    pulse_reset();
    step(1'b1, 1'b1, 4'd4, 16'h0101, 1'b1, 4'd5, 16'h0202);
    step(1'b1, 1'b1, 4'd6, 16'h0303, 1'b1, 4'd7, 16'h0404);
    chk("burst_mem_ready", 16'(mem_ready), 16'd0);
    chk("burst_alu_ready", 16'(alu_ready), 16'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'(8 + i), 16'(i), 1'b1, 4'(12 + i), 16'(i + 16));
    repeat (5) begin
      step(1'b0, 1'b1, 4'd9, 16'h9999, 1'b1, 4'd9, 16'h9999);
      chk("stall_alu_ready", 16'(alu_ready), 16'd0);
    end
    repeat (6) idle_step();
    step(1'b1, 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222);
    pulse_reset();
    chk("rst_mid_idle", 16'(idle), 16'd1);
    step(1'b1, 1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 16'd0);
    chk("post_rst_c1_we", 16'(write_en), 16'd0);
    idle_step();
    chk("post_rst_c2_we", 16'(write_en), 16'd1);
    chk("post_rst_c2_data", data_in, 16'hBEEF);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) pulse_reset();
      else step(1'($urandom_range(99) < 85), 1'($urandom_range(1)), 4'($urandom), 16'($urandom),
                1'($urandom_range(1)), 4'($urandom), 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
